// File: rtl/bcd_sched.sv
// bcd_sched: round-robin scheduler that shares one combinational binary-to-BCD
// converter among N_REQ requesters. Two-stage pipeline (S1 capture, S2
// response register) with valid/ready flow control on both sides.

// bcd: combinational 8-bit binary to 3-digit BCD (shift-and-add-3).
module bcd (
  input  logic [7:0] bin,
  output logic [9:0] dec
);

  logic [17:0] sh;

  // Double-dabble: correct each BCD digit before every left shift.
  always_comb begin
    // NOTE: every always_comb target gets a value before any branch, so no latch is inferred.
    sh = {10'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      sh = sh << 1;
    end
    dec = sh[17:8];
  end

endmodule

module bcd_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_bin,
  output logic [9:0]           rsp_bcd,
  output logic [15:0]          conv_cnt
);

  // Round-robin pointer and stage-1 register.
  logic [ID_W-1:0] ptr;
  logic            s1_v;
  logic [7:0]      s1_bin;
  logic [ID_W-1:0] s1_id;

  // Arbitration results.
  logic            found;
  logic [ID_W-1:0] grant_id;
  logic [7:0]      grant_data;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  logic s2_free;
  logic s1_free;
  logic req_fire;
  logic [9:0] conv_bcd;

  // S2 can take new data when empty or being drained; S1 likewise behind S2.
  assign s2_free  = !rsp_valid || rsp_ready;
  assign s1_free  = !s1_v || s2_free;
  assign req_fire = |req_ready;

  // Search from ptr upward (modulo N_REQ) for the first valid requester.
  // The extra sum bit keeps ptr+k from aliasing when N_REQ is not a power of two.
  always_comb begin
    found      = 1'b0;
    grant_id   = '0;
    grant_data = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant_id   = idx;
        grant_data = req_data[{idx, 3'b000} +: 8];
      end
    end
  end

  // One-hot ready to the winner only when S1 can accept and not in reset.
  always_comb begin
    req_ready = '0;
    if (found && s1_free && !rst) req_ready[grant_id] = 1'b1;
  end

  // Pointer moves just past the winner, wrapping at N_REQ.
  assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Arbiter pointer and stage-1 capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ptr    <= '0;
      s1_v   <= 1'b0;
      s1_bin <= '0;
      s1_id  <= '0;
    end else if (req_fire) begin
      ptr    <= next_ptr;
      s1_v   <= 1'b1;
      s1_bin <= grant_data;
      s1_id  <= grant_id;
    end else if (s1_free) begin
      s1_v   <= 1'b0;
    end
  end

  bcd u_bcd (
    .bin (s1_bin),
    .dec (conv_bcd)
  );

  // Stage-2 response register; holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_bin   <= '0;
      rsp_bcd   <= '0;
      rsp_id    <= '0;
    end else if (s2_free) begin
      rsp_valid <= s1_v;
      rsp_bin   <= s1_bin;
      rsp_bcd   <= conv_bcd;
      rsp_id    <= s1_id;
    end
  end

  // Count completed response handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         conv_cnt <= '0;
    else if (rsp_valid && rsp_ready) conv_cnt <= conv_cnt + 16'd1;
  end

endmodule

// File: tb/tb_bcd_sched.sv
// tb_bcd_sched: directed scoreboard bench for bcd_sched (N_REQ=4).
// Handshakes push expected responses; a monitor pops and compares on every
// response handshake. Directed phases add hand-computed spot checks.
module tb_bcd_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_bin;
  logic [9:0]  rsp_bcd;
  logic [15:0] conv_cnt;

  typedef struct {
    logic [1:0] id;
    logic [7:0] bin;
    logic [9:0] bcd;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  bcd_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bin   (rsp_bin),
    .rsp_bcd   (rsp_bcd),
    .conv_cnt  (conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] bcd_model(input logic [7:0] b);
    int v;
    v = int'(b);
    return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Push the expected response for every accepted request.
  always @(negedge clk) begin : hs_mon
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id  = 2'(i);
          e.bin = req_data[8*i +: 8];
          e.bcd = bcd_model(e.bin);
          sb.push_back(e);
        end
      end
    end
  end

  // Pop and compare on every response handshake.
  always @(negedge clk) begin : rsp_mon
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d bin=%0d with empty scoreboard", rsp_id, rsp_bin);
      end else begin
        e = sb.pop_front();
        check("rsp_id",  32'(rsp_id),  32'(e.id));
        check("rsp_bin", 32'(rsp_bin), 32'(e.bin));
        check("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    rsp_ready = 1'b1;
    req_valid = '0;
    while ((sb.size() != 0 || rsp_valid) && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Requester r sends values 0,1,2,... (mod 256) back-to-back, n in total.
  task automatic stream(input int n, input int r);
    int  sent;
    int  budget;
    logic hs;
    sent   = 0;
    budget = 0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_data[8*r +: 8] = 8'(sent);
    while (sent < n && budget < n + 100) begin
      @(negedge clk);
      hs = req_ready[r];
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        req_data[8*r +: 8] = 8'(sent);
      end
      budget++;
    end
    req_valid = '0;
    check("stream_sent", 32'(sent), 32'(n));
  endtask

  initial begin : watchdog
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1_bin [4] = '{8'd0, 8'd99, 8'd200, 8'd255};
  logic [9:0] t1_bcd [4] = '{10'h000, 10'h099, 10'h200, 10'h255};
  logic [9:0] fair_bcd [4] = '{10'h010, 10'h020, 10'h030, 10'h040};

  initial begin : stim
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h0102_0304;
    rsp_ready = 1'b1;

    // Reset state, with requests offered to prove req_ready is gated.
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_bin",   32'(rsp_bin),   32'd0);
    check("rst_rsp_bcd",   32'(rsp_bcd),   32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_conv_cnt",  32'(conv_cnt),  32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;

    // Single requests from requester 2 with two-cycle latency.
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b0100;
      req_data[23:16] = t1_bin[k];
      @(negedge clk);
      check("t1_grant", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("t1_lat_t1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("t1_lat_t2", 32'(rsp_valid), 32'd1);
      check("t1_id",     32'(rsp_id),    32'd2);
      check("t1_bin",    32'(rsp_bin),   32'(t1_bin[k]));
      check("t1_bcd",    32'(rsp_bcd),   32'(t1_bcd[k]));
      @(posedge clk); #1;
    end
    drain();

    // Fairness: all four requesters held valid.
    do_reset();
    req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
        check("fair_rsp_bcd",   32'(rsp_bcd),   32'(fair_bcd[(c - 2) % 4]));
      end
      @(posedge clk); #1;
    end
    drain();

    // Backpressure: two grants, then stall into FULL and recover.
    req_data  = {8'd123, 8'd0, 8'd77, 8'd5};
    req_valid = 4'b1010;
    @(negedge clk);
    check("bp_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_grant3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_full_ready", 32'(req_ready), 32'd0);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id",    32'(rsp_id),    32'd1);
      check("bp_hold_bin",   32'(rsp_bin),   32'd77);
      check("bp_hold_bcd",   32'(rsp_bcd),   32'h077);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_recover_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Exhaustive sweep from requester 0.
    do_reset();
    stream(256, 0);
    drain();
    check("sweep_conv_cnt", 32'(conv_cnt), 32'd256);

    // Reset while FULL: in-flight data discarded, pointer back to 0.
    req_data  = {8'd0, 8'd201, 8'd200, 8'd0};
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mf_full_ready", 32'(req_ready), 32'd0);
    check("mf_full_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mf_rst_valid", 32'(rsp_valid), 32'd0);
    check("mf_rst_ready", 32'(req_ready), 32'd0);
    req_data  = {8'd6, 8'd9, 8'd8, 8'd7};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mf_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Counter wrap after 65536 conversions.
    do_reset();
    stream(65535, 0);
    drain();
    check("wrap_ffff", 32'(conv_cnt), 32'hFFFF);
    stream(1, 0);
    drain();
    check("wrap_zero", 32'(conv_cnt), 32'd0);

    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_sched.md
# bcd_sched

Shared-resource scheduler for the combinational 8-bit binary-to-BCD converter (`bcd`). Up to N_REQ requesters present 8-bit binary values over valid/ready handshakes. A round-robin arbiter grants one requester per cycle into a two-stage pipeline built around a single `bcd` instance. Each result leaves on one valid/ready response port, tagged with the requester ID and echoing the input.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: requester-ID width; must equal ceil(log2(N_REQ)).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  bit i: requester i offers data.
- `req_data`  in  8*N_REQ  requester i binary value on [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot-or-zero; bit i: requester i accepted this cycle.
- `rsp_valid`  out  1  response holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that supplied the value.
- `rsp_bin`  out  8  echoed binary input.
- `rsp_bcd`  out  10  [9:8] hundreds, [7:4] tens, [3:0] ones.
- `conv_cnt`  out  16  count of completed response handshakes; wraps.

## Operation
- Datapath: S1 register (`s1_v`, `s1_bin`, `s1_id`) → `bcd` instance (combinational) → S2 register (`rsp_valid`, `rsp_bin`, `rsp_bcd`, `rsp_id`).
- Stall logic:
  - `s2_free = !rsp_valid || rsp_ready`.
  - `s1_free = !s1_v || s2_free`.
- Arbiter:
  - Round-robin pointer `ptr` (ID_W bits, reset 0).
  - The winner is the first i with `req_valid[i]` searching ptr, ptr+1, …, wrapping modulo N_REQ.
  - `req_ready[winner] = s1_free && !rst`; all other bits are 0.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On a request handshake with winner g:
  - S1 loads `req_data[g]` and g, and sets `s1_v`.
  - `ptr <= (g+1) mod N_REQ`.
  - With no handshake, `ptr` holds.
- S1 → S2:
  - When `s2_free`, S2 loads S1 and `rsp_valid <= s1_v`.
  - When `s1_free` and there is no request handshake, `s1_v <= 0`.
- Occupancy states `{s1_v, rsp_valid}`:
  - EMPTY 00: accept a request → 10.
  - S1ONLY 10: advance → 01, or → 11 with a new request.
  - S2ONLY 01:
    - `rsp_ready` high: → 10 with a request, else → 00.
    - `rsp_ready` low: stays 01, and a request moves to 11.
  - FULL 11: with `rsp_ready` low, holds and `req_ready` is all 0. With `rsp_ready` high, stays 11 if a request arrives, else → 01.
- Conversion is exact for 0..255, e.g. 255 → 10'h255 (hundreds 2, tens 5, ones 5).
- `conv_cnt` increments on `rsp_valid && rsp_ready`; 0xFFFF wraps to 0x0000.
- Requester withdrawal: if `req_valid` drops before it is granted, nothing is captured for that requester.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_bin`=0, `rsp_bcd`=0, `rsp_id`=0.
  - `conv_cnt`=0, `ptr`=0, `s1_v`=0.
  - `req_ready`=0 while `rst` is high.
- Latency: a handshake in cycle t gives `rsp_valid` high in cycle t+2 with its data. No combinational path from `req_*` to `rsp_*`.
- Throughput: one result per cycle while `rsp_ready` stays high and requests keep arriving.
- Response stability: while `rsp_valid && !rsp_ready`, all `rsp_*` outputs are stable.
- Ordering: responses come out in grant order; no reordering or duplication.
- Reset mid-operation: asserting `rst` immediately clears both stages and the pointer. In-flight values are discarded and never appear on `rsp_*`.
- Backpressure recovery: raising `rsp_ready` in FULL gives `req_ready` high in that same cycle (a new request fills S1 as S1 advances to S2).

## Test plan
- Reset then single request: requester 2 sends 8'd0, 8'd99, 8'd200 and 8'd255, each as its own request with `rsp_ready`=1. Each response appears 2 cycles after its handshake with `rsp_id`=2 and `rsp_bcd` = 10'h000, 10'h099, 10'h200, 10'h255 respectively.
- Fairness: all four requesters hold `req_valid` with values 10, 20, 30, 40 and `rsp_ready`=1. Grants go 0,1,2,3,0,… and responses arrive back-to-back with `rsp_bcd` 10'h010, 10'h020, 10'h030, 10'h040.
- Backpressure: `rsp_ready`=0 after two grants. The pipe reaches FULL, `req_ready` goes all 0, and `rsp_*` stay stable. After `rsp_ready`=1, both results drain in order with no loss.
- Exhaustive sweep: requester 0 sends 0..255 at full rate. Every `rsp_bcd` matches the decimal digits of `rsp_bin` and `conv_cnt` ends at 256.
- Reset mid-flight: assert `rst` while in FULL. `rsp_valid` drops to 0 immediately, no stale response appears after release, and the next grant goes to requester 0.
- Counter wrap: preload by running 65 536 conversions; `conv_cnt` reads 0 afterwards.
